fp16_mul_arbiter: RTL

Shares one instance of the team's 4-stage pipelined FP16 multiplier between NUM_REQ independent requesters. It accepts operand pairs over per-requester valid/ready ports and issues at most one per cycle using round-robin arbitration. Each in-flight operation carries a requester tag down a shadow pipeline so that the result and flags are steered back to the right requester. Per-requester credit counting guarantees that a multiplier result never arrives to a full response buffer, since the multiplier has no backpressure.

---
 rtl/fp16_mul_arbiter_if.sv | 15 +
 rtl/fp16_mul_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/fp16_mul_arbiter_if.sv
// fp16_mul_arbiter_if: per-requester operand request and response bundle
interface fp16_mul_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [16*NUM_REQ-1:0] resp_data;
    logic [4*NUM_REQ-1:0]  resp_flags;
    modport master (output req_valid, req_a, req_b, resp_ready,
                    input  req_ready, resp_valid, resp_data, resp_flags);
    modport slave  (input  req_valid, req_a, req_b, resp_ready,
                    output req_ready, resp_valid, resp_data, resp_flags);
endinterface

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one pipelined FP16 multiplier with credit-protected response FIFOs
module fp16_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LAT        = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    fp16_mul_arbiter_if.slave bus,
    output logic              mul_valid_in,
    output logic [15:0]       mul_num1,
    output logic [15:0]       mul_num2,
    input  logic              mul_valid_out,
    input  logic [15:0]       mul_result,
    input  logic [3:0]        mul_flags,
    output logic              idle,
    output logic              tag_err
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);

    logic [CW-1:0]         cnt [NUM_REQ];
    logic [IW-1:0]         last, gidx;
    logic                  found;
    logic [NUM_REQ-1:0]    elig, grant, pop, rvalid;
    logic [LAT-1:0]        tv;
    logic [IW-1:0]         ti [LAT];
    logic [PW:0]           wp [NUM_REQ];
    logic [PW:0]           rp [NUM_REQ];
    logic [19:0]           mem [NUM_REQ][RESP_DEPTH];
    logic [16*NUM_REQ-1:0] rdata;
    logic [4*NUM_REQ-1:0]  rflags;
    logic                  push;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign elig[g]            = bus.req_valid[g] && cnt[g] < CW'(RESP_DEPTH);
        assign rvalid[g]          = wp[g] != rp[g];
        assign pop[g]             = rvalid[g] && bus.resp_ready[g];
        assign rdata[16*g +: 16]  = mem[g][rp[g][PW-1:0]][19:4];
        assign rflags[4*g +: 4]   = mem[g][rp[g][PW-1:0]][3:0];
    end

    assign bus.resp_valid = rvalid;
    assign bus.resp_data  = rdata;
    assign bus.resp_flags = rflags;
    assign bus.req_ready  = grant;
    assign grant          = (found && rstn) ? NUM_REQ'(1) << gidx : '0;
    assign mul_valid_in   = |grant;
    assign mul_num1       = mul_valid_in ? bus.req_a[16*gidx +: 16] : '0;
    assign mul_num2       = mul_valid_in ? bus.req_b[16*gidx +: 16] : '0;
    assign push           = mul_valid_out && tv[LAT-1];

    // Round-robin search starting just after the last granted requester
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && elig[(int'(last) + k) % NUM_REQ]) begin
                found = 1'b1;
                gidx  = IW'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    // Idle when no requester holds any credit
    always_comb begin
        idle = 1'b1;
        for (int k = 0; k < NUM_REQ; k++)
            if (cnt[k] != '0) idle = 1'b0;
    end

    // Shadow tag pipe carrying {valid, requester} alongside the multiplier stages
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tv <= '0;
            for (int k = 0; k < LAT; k++) ti[k] <= '0;
        end else begin
            tv[0] <= mul_valid_in;
            ti[0] <= gidx;
            for (int k = 1; k < LAT; k++) begin
                tv[k] <= tv[k-1];
                ti[k] <= ti[k-1];
            end
        end
    end

    // Credits, FIFO pointers, arbitration pointer and sticky tag error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last    <= IW'(NUM_REQ - 1);
            tag_err <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt[k] <= '0;
                wp[k]  <= '0;
                rp[k]  <= '0;
            end
        end else begin
            if (mul_valid_in) last <= gidx;
            if (mul_valid_out != tv[LAT-1]) tag_err <= 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt[k] <= cnt[k] + CW'(grant[k]) - CW'(pop[k]);
                if (pop[k]) rp[k] <= rp[k] + (PW+1)'(1);
                if (push && ti[LAT-1] == IW'(k)) wp[k] <= wp[k] + (PW+1)'(1);
            end
        end
    end

    // Response storage; contents are only observed through valid pointers
    always_ff @(posedge clk) begin
        if (push) mem[ti[LAT-1]][wp[ti[LAT-1]][PW-1:0]] <= {mul_result, mul_flags};
    end
endmodule
